// File: rtl/text_char_serializer.sv
// text_char_serializer: fetches charset rows from a synchronous ROM and shifts them out
// as fg/bg colour indices, one pixel per pix_ce, with a one-deep pattern buffer.
module text_char_serializer #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          pix_ce,
    input  logic          flush,
    input  logic          char_valid,
    output logic          char_ready,
    input  logic [7:0]    char_code,
    input  logic [2:0]    char_row,
    input  logic [1:0]    charset_sel,
    input  logic [2*CW-1:0] attr,
    output logic [12:0]   rom_address,
    input  logic [DW-1:0] rom_q,
    output logic          pixel_valid,
    output logic [CW-1:0] pixel_color,
    output logic          underrun
);
    localparam int NW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nx;

    logic            accept, load, shift, buf_full;
    logic [DW-1:0]   buf_pat, shift_pat, src_pat;
    logic [2*CW-1:0] fetch_attr, buf_attr, shift_attr, src_attr;
    logic [NW-1:0]   cnt;

    always_comb begin
        char_ready = (state == IDLE) && !buf_full && !flush;
        accept     = char_valid && char_ready;
        load       = pix_ce && (cnt == '0) && buf_full;
        shift      = pix_ce && (cnt != '0);
        src_pat    = load ? buf_pat : shift_pat;
        src_attr   = load ? buf_attr : shift_attr;
        state_nx   = flush ? IDLE :
                     accept ? ADDR :
                     (state == ADDR) ? DATA :
                     (state == DATA) ? IDLE : state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            fetch_attr  <= '0;
            buf_pat     <= '0;
            buf_attr    <= '0;
            buf_full    <= 1'b0;
            shift_pat   <= '0;
            shift_attr  <= '0;
            cnt         <= '0;
            pixel_valid <= 1'b0;
            pixel_color <= '0;
            underrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (flush) begin
                buf_full    <= 1'b0;
                cnt         <= '0;
                pixel_valid <= 1'b0;
            end else begin
                if (accept) begin
                    rom_address <= {charset_sel, char_code, char_row};
                    fetch_attr  <= attr;
                end
                // DATA only runs with an empty buffer, so it never races the shifter's load
                if (state == DATA) begin
                    buf_pat  <= rom_q;
                    buf_attr <= fetch_attr;
                    buf_full <= 1'b1;
                end else if (load) begin
                    buf_full <= 1'b0;
                end
                if (load || shift) begin
                    pixel_valid <= 1'b1;
                    pixel_color <= src_pat[DW-1] ? src_attr[2*CW-1:CW] : src_attr[CW-1:0];
                    shift_pat   <= src_pat << 1;
                    shift_attr  <= src_attr;
                    cnt         <= load ? NW'(DW - 1) : cnt - 1'b1;
                end else if (pix_ce) begin
                    pixel_valid <= 1'b0;
                    pixel_color <= '0;
                    underrun    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_text_char_serializer.sv
// tb_text_char_serializer: directed checks of fetch timing, pixel order, pacing, flush and reset.
module tb_text_char_serializer;
    logic        clock = 1'b0, reset_n = 1'b0, pix_ce = 1'b0, flush = 1'b0, char_valid = 1'b0;
    logic        char_ready, pixel_valid, underrun;
    logic [7:0]  char_code = '0, attr = '0, rom_q = '0;
    logic [2:0]  char_row = '0;
    logic [1:0]  charset_sel = '0;
    logic [12:0] rom_address;
    logic [3:0]  pixel_color;
    logic [3:0]  pix_q[$];
    logic        ce_s;
    int          checks = 0, failures = 0, und_cnt = 0;

    text_char_serializer dut (
        .clock(clock), .reset_n(reset_n), .pix_ce(pix_ce), .flush(flush),
        .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
        .char_row(char_row), .charset_sel(charset_sel), .attr(attr),
        .rom_address(rom_address), .rom_q(rom_q), .pixel_valid(pixel_valid),
        .pixel_color(pixel_color), .underrun(underrun)
    );

    always #5 clock = ~clock;

    // ROM stub: pattern equals the character code, except the one documented entry
    always @(posedge clock) rom_q <= (rom_address == 13'h120B) ? 8'hA5 : rom_address[10:3];

    always @(posedge clock) begin
        ce_s = pix_ce;
        #1;
        if (ce_s && pixel_valid) pix_q.push_back(pixel_color);
        if (ce_s && underrun) und_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] code, input logic [2:0] row, input logic [1:0] bank,
                        input logic [7:0] at);
        int g = 0;
        bit done = 0;
        char_valid = 1'b1; char_code = code; char_row = row; charset_sel = bank; attr = at;
        while (!done && g < 50) begin
            done = char_ready;
            @(negedge clock);
            g++;
        end
        char_valid = 1'b0;
        chk("accept", 32'(done), 1);
    endtask

    task automatic run_pix(input int n);
        pix_q.delete();
        pix_ce = 1'b1;
        repeat (n) @(negedge clock);
        pix_ce = 1'b0;
    endtask

    task automatic check_pix(input string tag, input logic [7:0] pat, input logic [3:0] fg,
                             input logic [3:0] bg);
        chk({tag, "_count"}, 32'(pix_q.size()), 8);
        for (int i = 0; i < 8 && i < pix_q.size(); i++)
            chk($sformatf("%s_px%0d", tag, i), 32'(pix_q[i]), 32'(pat[7-i] ? fg : bg));
    endtask

    initial begin
        logic [7:0] p39;
        int g;
        repeat (2) @(negedge clock);
        chk("rst_valid", 32'(pixel_valid), 0);
        chk("rst_color", 32'(pixel_color), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_addr", 32'(rom_address), 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 32'(char_ready), 1);

        // idle line: every enabled pixel underruns
        pix_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("idle_underrun", 32'(underrun), 1);
            chk("idle_valid", 32'(pixel_valid), 0);
            chk("idle_color", 32'(pixel_color), 0);
        end
        pix_ce = 1'b0;
        @(negedge clock);
        chk("idle_underrun_off", 32'(underrun), 0);

        // basic fetch and pixel order
        send(8'h41, 3'd3, 2'd2, 8'hF1);
        chk("addr_120b", 32'(rom_address), 32'h120B);
        chk("busy_in_addr", 32'(char_ready), 0);
        repeat (3) @(negedge clock);
        chk("ready_buf_full", 32'(char_ready), 0);
        run_pix(8);
        begin
            logic [3:0] e37[8] = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};
            chk("t37_count", 32'(pix_q.size()), 8);
            for (int i = 0; i < 8 && i < pix_q.size(); i++)
                chk($sformatf("t37_px%0d", i), 32'(pix_q[i]), 32'(e37[i]));
        end

        // back-to-back characters with pix_ce held high
        send(8'hFF, 3'd0, 2'd0, 8'hA5);
        repeat (3) @(negedge clock);
        pix_q.delete();
        und_cnt = 0;
        pix_ce = 1'b1;
        send(8'h00, 3'd0, 2'd0, 8'hA5);
        g = 0;
        while (pix_q.size() < 16 && g < 100) begin
            @(negedge clock);
            g++;
        end
        pix_ce = 1'b0;
        chk("t38_count", 32'(pix_q.size()), 16);
        chk("t38_underrun", 32'(und_cnt), 0);
        for (int i = 0; i < 16 && i < pix_q.size(); i++)
            chk($sformatf("t38_px%0d", i), 32'(pix_q[i]), (i < 8) ? 32'hA : 32'h5);
        repeat (2) @(negedge clock);

        // pix_ce every 4th cycle: outputs hold between enables
        p39 = 8'h3C;
        send(p39, 3'd0, 2'd0, 8'h72);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) chk("t39_ready_before", 32'(char_ready), 0);
            pix_ce = 1'b1;
            @(negedge clock);
            pix_ce = 1'b0;
            if (i == 0) chk("t39_ready_after", 32'(char_ready), 1);
            chk($sformatf("t39_px%0d", i), 32'(pixel_color), 32'(p39[7-i] ? 4'h7 : 4'h2));
            repeat (3) @(negedge clock);
            chk($sformatf("t39_hold%0d", i), 32'(pixel_color), 32'(p39[7-i] ? 4'h7 : 4'h2));
            chk($sformatf("t39_hvalid%0d", i), 32'(pixel_valid), 1);
        end

        // flush during ADDR drops the in-flight character
        send(8'h81, 3'd0, 2'd0, 8'hD4);
        flush = 1'b1;
        #1 chk("flush_blocks_ready", 32'(char_ready), 0);
        @(negedge clock);
        flush = 1'b0;
        repeat (3) @(negedge clock);
        chk("flush_ready", 32'(char_ready), 1);
        chk("flush_valid", 32'(pixel_valid), 0);
        send(8'h0F, 3'd0, 2'd0, 8'hC3);
        repeat (3) @(negedge clock);
        run_pix(8);
        check_pix("t41", 8'h0F, 4'hC, 4'h3);

        // asynchronous reset mid-shift abandons the character
        send(8'hF0, 3'd0, 2'd0, 8'h96);
        repeat (3) @(negedge clock);
        run_pix(4);
        chk("t42_pre_count", 32'(pix_q.size()), 4);
        reset_n = 1'b0;
        #1;
        chk("t42_async_valid", 32'(pixel_valid), 0);
        chk("t42_async_color", 32'(pixel_color), 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_pix(10);
        chk("t42_no_stale", 32'(pix_q.size()), 0);
        send(8'hAA, 3'd0, 2'd0, 8'hE1);
        repeat (3) @(negedge clock);
        run_pix(8);
        check_pix("t42_new", 8'hAA, 4'hE, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_char_serializer.md
TEXT_CHAR_SERIALIZER -- requirements
Module: text_char_serializer

Interface
REQ-001 Parameter DW, default 8: charset ROM data width and pixels per character cell.
REQ-002 Parameter CW, default 4: colour index width.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 pix_ce  input  1  pixel clock enable; one pixel is emitted per cycle where pix_ce=1.
REQ-006 flush  input  1  synchronous line-start flush; discards all buffered and in-flight work.
REQ-007 char_valid  input  1  character request valid.
REQ-008 char_ready  output  1  request accepted on cycles where char_valid=1 and char_ready=1.
REQ-009 char_code  input  8  character code.
REQ-010 char_row  input  3  scanline within the 8-line cell.
REQ-011 charset_sel  input  2  charset bank.
REQ-012 attr  input  2*CW  attr[2*CW-1:CW] is fg, attr[CW-1:0] is bg.
REQ-013 rom_address  output  13  registered address to the synchronous charset ROM.
REQ-014 rom_q  input  DW  ROM data; valid one clock after rom_address changes.
REQ-015 pixel_valid  output  1  registered; pixel_color is meaningful.
REQ-016 pixel_color  output  CW  registered pixel colour index.
REQ-017 underrun  output  1  one-cycle pulse when a pixel is due but no pattern is available.

Function
REQ-018 Fetch FSM SHALL have states IDLE, ADDR and DATA.
REQ-019 char_ready SHALL be 1 only when all three hold: state=IDLE, buffer empty (buf_full=0), flush=0.
REQ-020 On accept: rom_address <= {charset_sel, char_code, char_row}; attr is captured to a fetch register; state -> ADDR.
REQ-021 In ADDR, the next edge SHALL move to DATA unconditionally; the ROM output becomes valid during DATA.
REQ-022 In DATA, the edge SHALL load buf_pat <= rom_q and buf_attr <= fetched attr, set buf_full=1, and return to IDLE.
REQ-023 Accept-to-buf_full latency SHALL be exactly 3 clock edges, independent of pix_ce.
REQ-024 Shifter state: shift_pat (DW bits), shift_attr, bit counter cnt (0..DW-1 remaining after current pixel).
REQ-025 On a pix_ce edge with cnt=0 and buf_full=1: emit colour from buf_pat[DW-1]; load shift_pat <= buf_pat<<1 and shift_attr <= buf_attr; set cnt <= DW-1; clear buf_full; set pixel_valid=1.
REQ-026 On a pix_ce edge with cnt>0: emit colour from shift_pat[DW-1]; shift_pat <<= 1; cnt decrements; pixel_valid=1.
REQ-027 Pixel bit 1 SHALL select fg and bit 0 SHALL select bg; pixels are emitted MSB first.
REQ-028 On a pix_ce edge with cnt=0 and buf_full=0: pixel_valid=0, pixel_color=0, underrun=1 for that cycle only.
REQ-029 On cycles with pix_ce=0: pixel_valid, pixel_color and shifter state SHALL hold; underrun=0.
REQ-030 With an uninterrupted supply, consecutive characters SHALL produce exactly DW pixels each, with no gap pixels.
REQ-031 buf_full set (DATA) and clear (REQ-025) cannot coincide, because a fetch starts only when the buffer is empty; no extra arbitration is required.
REQ-032 flush=1 SHALL take priority over every other action: state -> IDLE, buf_full=0, cnt=0, pixel_valid=0, underrun=0; no request is accepted on that cycle; rom_address holds its value.
REQ-033 After a flush, a request accepted mid-fetch SHALL not be delivered, and a ROM result arriving afterwards SHALL be ignored.

Reset
REQ-034 reset_n=0 SHALL asynchronously clear: state=IDLE, buf_full=0, cnt=0, shift_pat=0, rom_address=0, pixel_valid=0, pixel_color=0, underrun=0.
REQ-035 char_ready SHALL be 1 on the first edge after reset_n deasserts, provided flush=0.
REQ-036 Reset asserted mid-fetch or mid-shift SHALL abandon all work; no pixel from the abandoned work SHALL appear after release.

Verification
REQ-037 Accept code 0x41, row 3, bank 2 -> next edge rom_address=0x120B; ROM data 0xA5 with fg=0xF, bg=0x1 -> pixels F,1,F,1,1,F,1,F.
REQ-038 pix_ce held 1, two back-to-back characters 0xFF and 0x00 -> 16 consecutive valid pixels (8 fg then 8 bg), underrun never asserted.
REQ-039 pix_ce every 4th cycle -> pixel outputs hold between enables; char_ready reasserts only after buffer loads into shifter.
REQ-040 No requests, pix_ce=1 -> pixel_valid=0, pixel_color=0, underrun pulses on each pix_ce cycle.
REQ-041 flush asserted in ADDR state -> that character never emitted; next accepted character emitted first, correctly.
REQ-042 reset_n low during shifting at cnt=4 -> outputs 0 immediately (asynchronous); after release the first valid pixel comes from a new request only.
